// File: rtl/noc_pkg.sv
// Shared ring NoC definitions: flit encoding, owner codes, link and
// route-lock state encodings.
package noc_pkg;

    localparam int FLIT_W = 8;
    localparam int NODE_W = 2;

    localparam logic [5:0] HEAD_TAG = 6'b101111;
    localparam logic [FLIT_W-1:0] TAIL_FLIT = 8'hFF;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_UP   = 2'b01,
        OWN_NI   = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_UP   = 2'd1,
        L_NI   = 2'd2
    } link_state_e;

    typedef enum logic [1:0] {
        R_NONE  = 2'd0,
        R_LINK  = 2'd1,
        R_EJECT = 2'd2
    } route_lock_e;

    function automatic logic is_head(input logic [FLIT_W-1:0] f);
        return f[FLIT_W-1 -: 6] == HEAD_TAG;
    endfunction

    function automatic logic is_tail(input logic [FLIT_W-1:0] f);
        return f == TAIL_FLIT;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream credit tracker: up/down counter bounded at CREDITS,
// flags a return that would exceed the buffer depth.
module credit_counter #(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dec,
    input  logic inc,
    output logic avail,
    output logic ovf
);

    localparam logic [CW-1:0] MAX = CW'(CREDITS);

    logic [CW-1:0] count;

    // Credit availability and overflow detection from current count
    always_comb begin
        avail = count != '0;
        ovf   = inc && !dec && (count == MAX);
    end

    // Count update; simultaneous send and return cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= MAX;
        end else if (dec && !inc && avail) begin
            count <= count - 1'b1;
        end else if (inc && !dec && !ovf) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ring_link_arbiter.sv
// Ring node link scheduler: per-packet round-robin between upstream and NI,
// local ejection, credit flow control. Perf counters under RING_ARB_PERF_EN.
module ring_link_arbiter
    import noc_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  current_node,
    input  logic [7:0]  up_flit,
    input  logic        up_valid,
    output logic        up_ready,
    input  logic [7:0]  ni_flit,
    input  logic        ni_valid,
    output logic        ni_ready,
    output logic [7:0]  link_flit,
    output logic        link_valid,
    input  logic        credit_in,
    output logic [7:0]  ej_flit,
    output logic        ej_valid,
    input  logic        ej_ready,
    output logic [1:0]  link_owner,
    output logic        proto_err
`ifdef RING_ARB_PERF_EN
    ,
    output logic [15:0] pkt_up_cnt,
    output logic [15:0] pkt_ni_cnt,
    output logic [15:0] pkt_ej_cnt
`endif
);

    link_state_e lstate, lstate_nxt;
    route_lock_e rlock, rlock_nxt;
    logic rr_ni_pref, rr_nxt;

    logic cred_ok, cred_ovf;
    logic up_head, up_tail, up_me;
    logic ni_head, ni_tail;
    logic ej_space;
    logic up_req, ni_req;
    logic grant_up, grant_ni;
    logic up_xfer, ni_xfer;
    logic up_link, up_ej, ni_link;
    logic err, send;
    logic [FLIT_W-1:0] send_flit;

    credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (send),
        .inc   (credit_in),
        .avail (cred_ok),
        .ovf   (cred_ovf)
    );

    // Flit classification and round-robin grant among link requesters
    always_comb begin
        up_head  = is_head(up_flit);
        up_tail  = is_tail(up_flit);
        up_me    = up_flit[NODE_W-1:0] == current_node;
        ni_head  = is_head(ni_flit);
        ni_tail  = is_tail(ni_flit);
        ej_space = !ej_valid || ej_ready;
        up_req   = up_valid && up_head && !up_me &&
                   (rlock == R_NONE) && (lstate == L_IDLE);
        ni_req   = ni_valid && ni_head && (lstate == L_IDLE);
        grant_up = up_req && cred_ok && (!ni_req || !rr_ni_pref);
        grant_ni = ni_req && cred_ok && (!up_req || rr_ni_pref);
    end

    // Ready generation; stray body/tail flits are swallowed
    always_comb begin
        up_ready = 1'b0;
        unique case (rlock)
            R_EJECT: up_ready = ej_space;
            R_LINK:  up_ready = cred_ok;
            default: begin
                if (!up_head)
                    up_ready = 1'b1;
                else if (up_me)
                    up_ready = ej_space;
                else
                    up_ready = grant_up;
            end
        endcase
        ni_ready = 1'b0;
        if (lstate == L_NI)
            ni_ready = cred_ok;
        else if (ni_head)
            ni_ready = grant_ni;
        else
            ni_ready = 1'b1;
    end

    // Transfer steering and protocol error detection
    always_comb begin
        up_xfer   = up_valid && up_ready;
        ni_xfer   = ni_valid && ni_ready;
        up_link   = up_xfer && ((rlock == R_LINK) || grant_up);
        up_ej     = up_xfer && ((rlock == R_EJECT) ||
                    ((rlock == R_NONE) && up_head && up_me));
        ni_link   = ni_xfer && ((lstate == L_NI) || grant_ni);
        err       = (up_xfer && (rlock == R_NONE) && !up_head) ||
                    (ni_xfer && (lstate != L_NI) && !ni_head) ||
                    cred_ovf;
        send      = up_link || ni_link;
        send_flit = ni_link ? ni_flit : up_flit;
    end

    // Link FSM, route lock and rr pointer next-state
    always_comb begin
        lstate_nxt = lstate;
        rlock_nxt  = rlock;
        rr_nxt     = rr_ni_pref;
        unique case (lstate)
            L_IDLE: begin
                if (grant_up)
                    lstate_nxt = L_UP;
                else if (grant_ni)
                    lstate_nxt = L_NI;
            end
            L_UP: if (up_link && up_tail) lstate_nxt = L_IDLE;
            L_NI: if (ni_link && ni_tail) lstate_nxt = L_IDLE;
            default: lstate_nxt = L_IDLE;
        endcase
        unique case (rlock)
            R_NONE: begin
                if (grant_up)
                    rlock_nxt = R_LINK;
                else if (up_ej)
                    rlock_nxt = R_EJECT;
            end
            default: if (up_xfer && up_tail) rlock_nxt = R_NONE;
        endcase
        if (grant_up || grant_ni)
            rr_nxt = grant_up;
    end

    // Current link lock as owner code
    always_comb begin
        unique case (lstate)
            L_UP:    link_owner = OWN_UP;
            L_NI:    link_owner = OWN_NI;
            default: link_owner = OWN_NONE;
        endcase
    end

    // State registers and registered output stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lstate     <= L_IDLE;
            rlock      <= R_NONE;
            rr_ni_pref <= 1'b1;
            link_flit  <= '0;
            link_valid <= 1'b0;
            ej_flit    <= '0;
            ej_valid   <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            lstate     <= lstate_nxt;
            rlock      <= rlock_nxt;
            rr_ni_pref <= rr_nxt;
            link_valid <= send;
            if (send)
                link_flit <= send_flit;
            if (up_ej) begin
                ej_flit  <= up_flit;
                ej_valid <= 1'b1;
            end else if (ej_ready) begin
                ej_valid <= 1'b0;
            end
            if (err)
                proto_err <= 1'b1;
        end
    end

`ifdef RING_ARB_PERF_EN
    // Saturating completed-packet counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_up_cnt <= '0;
            pkt_ni_cnt <= '0;
            pkt_ej_cnt <= '0;
        end else begin
            if (up_link && up_tail && pkt_up_cnt != 16'hFFFF)
                pkt_up_cnt <= pkt_up_cnt + 16'd1;
            if (ni_link && ni_tail && pkt_ni_cnt != 16'hFFFF)
                pkt_ni_cnt <= pkt_ni_cnt + 16'd1;
            if (up_ej && up_tail && pkt_ej_cnt != 16'hFFFF)
                pkt_ej_cnt <= pkt_ej_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/ring_link_arbiter.md
Name: ring_link_arbiter

Overview:
- Packet-level (wormhole) scheduler for one router node of the 4-node ring NoC.
- Shares the single outgoing ring link between through-traffic from the upstream port and local injection from the NI, round-robin per packet.
- Steers upstream packets addressed to this node to the NI eject port.
- Tracks downstream buffer credits on the link; all outputs are registered.

Parameters:
- CREDITS, 4, downstream VC buffer depth in flits; initial and maximum credit count.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.

Ports:
- clk  in  1  router clock
- rst_n  in  1  asynchronous active-low reset
- current_node  in  2  this node's ring address
- up_flit  in  8  flit from upstream neighbour
- up_valid  in  1  up_flit valid
- up_ready  out  1  upstream flit accepted this cycle (combinational)
- ni_flit  in  8  injected flit from the local NI
- ni_valid  in  1  ni_flit valid
- ni_ready  out  1  NI flit accepted this cycle (combinational)
- link_flit  out  8  flit to downstream ring link (registered)
- link_valid  out  1  link_flit valid for exactly one cycle per flit
- credit_in  in  1  pulse: downstream freed one buffer slot
- ej_flit  out  8  flit ejected to the local NI (registered)
- ej_valid  out  1  ej_flit valid
- ej_ready  in  1  NI accepts ej_flit
- link_owner  out  2  00 none, 01 upstream, 10 NI (current link lock)
- proto_err  out  1  sticky: body/tail flit arrived with no open packet, or credit overflow

Behaviour:
- Flit format:
  - Head = {6'b101111, dest[1:0]}.
  - Tail = 8'hFF.
  - Any other value is a body flit.
  - Minimum packet is head + tail. A flit transfers when valid && ready.
- Reset (async, rst_n=0):
  - link_flit=0, link_valid=0, ej_flit=0, ej_valid=0, link_owner=00, proto_err=0.
  - Credit counter = CREDITS, route lock = NONE, rr pointer = NI-preferred.
  - Reset mid-packet drops the open packet; no state survives.
- Upstream route lock (NONE/LINK/EJECT):
  - In NONE, an upstream head with dest==current_node locks EJECT.
  - In NONE, any other upstream head requests the link.
  - A lock is released in the cycle its tail transfers.
- Link FSM states L_IDLE, L_UP, L_NI:
  - L_IDLE: requesters are an upstream head for link and a NI head.
    - One requester: grant it.
    - Both requesting in the same cycle: grant the one not granted last (rr pointer toggles on each grant).
  - The head transfers in the grant cycle.
  - L_UP / L_NI: only the owner may send; the other requester stalls.
  - Tail transfer -> L_IDLE next cycle. The other requester may win in that following cycle; no back-to-back grant in the tail cycle.
- Credits:
  - Link send allowed only if credit>0.
  - Each link flit decrements the counter; credit_in increments it.
  - Simultaneous send and credit_in: count unchanged.
  - credit_in at count==CREDITS: ignored, set proto_err.
- Ready and latency:
  - up_ready (EJECT) = ~ej_valid | ej_ready.
  - up_ready (link) = owner==UP && credit>0.
  - ni_ready = owner==NI (or being granted) && credit>0.
  - link_valid/ej_valid assert the cycle after transfer: 1-cycle latency, 1 flit/cycle throughput.
  - ej_valid held with ej_flit stable until ej_ready.
- Concurrency: an NI packet on the link and an upstream packet ejecting proceed in parallel.
- Protocol errors:
  - A non-head upstream flit with lock NONE is consumed (up_ready=1), discarded, and sets proto_err.
  - A non-head NI flit with no NI grant is handled the same way.
  - proto_err clears only on reset.

Optional Feature:
- Macro: RING_ARB_PERF_EN.
- Defined: adds outputs pkt_up_cnt[15:0], pkt_ni_cnt[15:0], pkt_ej_cnt[15:0].
  - Each increments on the corresponding tail transfer and saturates at 16'hFFFF.
  - All reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package noc_pkg:
  - HEAD_TAG=6'b101111, TAIL_FLIT=8'hFF, FLIT_W=8, NODE_W=2.
  - Owner encodings OWN_NONE/OWN_UP/OWN_NI.
  - Link FSM state constants.
- One natural sub-module, credit_counter (up/down saturating counter with overflow flag), instantiated once.

Test Plan:
- current_node=1; upstream sends 8'hBD (dest 1), 8'h12, 8'hFF with ej_ready=1 -> ej_flit BD,12,FF on ej_valid one cycle after each transfer; link_valid stays 0.
- Upstream 8'hBE,8'h34,8'hFF and NI 8'hBC,8'h56,8'hFF both valid at the same cycle after reset -> NI packet first (rr reset preference), link_owner=10; then upstream packet; link_flit order BC,56,FF,BE,34,FF.
- CREDITS=4, no credit_in, NI 6-flit packet -> exactly 4 link flits, ni_ready=0 thereafter; single credit_in pulse -> exactly one more flit.
- NI packet on link while upstream packet (dest==current_node) ejects -> both streams progress every cycle, no stalls.
- credit_in at count 4, or upstream 8'h12 while idle -> proto_err=1 and stays set; flit discarded.
- Assert rst_n=0 mid-packet -> all outputs 0 immediately, credit=4; a fresh head is accepted after release.
